// File: rtl/prism_sp_axil_pkg.sv
// Shared types for the SP local-memory AXI4-Lite bridges.
// Holds the response codes, the bridge FSM state type and the arbitration grant type.
package prism_sp_axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_MEM,
    WR_RESP,
    RD_MEM,
    RD_CAP,
    RD_RESP
  } lmem_bridge_state_t;

  typedef enum logic {
    GRANT_READ,
    GRANT_WRITE
  } grant_t;

endpackage

// File: rtl/prism_sp_lmem_axil_bridge.sv
// AXI4-Lite slave driving the MMR port of one SP local-memory BRAM (read latency 1).
// One transaction outstanding at a time; round-robin between write and read when both are offered.
module prism_sp_lmem_axil_bridge
  import prism_sp_axil_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int LMEM_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axil_awaddr,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [DATA_WIDTH-1:0]      s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]    s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [1:0]                 s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axil_araddr,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [DATA_WIDTH-1:0]      s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,
  output logic [LMEM_ADDR_WIDTH-1:0] lmem_addr,
  output logic                       lmem_en,
  output logic [DATA_WIDTH/8-1:0]    lmem_be,
  output logic [DATA_WIDTH-1:0]      lmem_data_in,
  input  logic [DATA_WIDTH-1:0]      lmem_data_out,
  output lmem_bridge_state_t         state_dbg
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("prism_sp_lmem_axil_bridge: DATA_WIDTH must be 32");
  end

  // Handshake rule: a ready output is a function of state and the matching valid;
  // every valid output is a function of state alone, never of the peer's ready.

  lmem_bridge_state_t state_q, state_d;
  grant_t             last_grant_q;
  logic               wr_cand, rd_cand, grant_wr, grant_rd;
  logic               aw_in_range, ar_in_range;
  logic [LMEM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]      wdata_q, rdata_q;
  logic [DATA_WIDTH/8-1:0]    be_q;
  logic [1:0]                 bresp_q, rresp_q;
  logic                       unused_addr_lsbs;

  assign wr_cand     = s_axil_awvalid && s_axil_wvalid;
  assign rd_cand     = s_axil_arvalid;
  assign aw_in_range = (s_axil_awaddr[AXI_ADDR_WIDTH-1:LMEM_ADDR_WIDTH+2] == '0);
  assign ar_in_range = (s_axil_araddr[AXI_ADDR_WIDTH-1:LMEM_ADDR_WIDTH+2] == '0);
  // Byte offsets within a word carry no meaning for a word-wide BRAM.
  assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  always_comb begin
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_cand && (!rd_cand || last_grant_q == GRANT_READ)) begin
          grant_wr = 1'b1;
          state_d  = aw_in_range ? WR_MEM : WR_RESP;
        end else if (rd_cand) begin
          grant_rd = 1'b1;
          state_d  = ar_in_range ? RD_MEM : RD_RESP;
        end
      end
      WR_MEM:  state_d = WR_RESP;
      WR_RESP: if (s_axil_bready) state_d = IDLE;
      RD_MEM:  state_d = RD_CAP;
      RD_CAP:  state_d = RD_RESP;
      RD_RESP: if (s_axil_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_READ;
    end else begin
      state_q <= state_d;
      if (grant_wr) last_grant_q <= GRANT_WRITE;
      if (grant_rd) last_grant_q <= GRANT_READ;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      bresp_q <= AXI_RESP_OKAY;
      rresp_q <= AXI_RESP_OKAY;
    end else begin
      if (grant_wr) begin
        bresp_q <= aw_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        if (aw_in_range) begin
          addr_q  <= s_axil_awaddr[LMEM_ADDR_WIDTH+1:2];
          wdata_q <= s_axil_wdata;
          be_q    <= s_axil_wstrb;
        end
      end
      if (grant_rd) begin
        rresp_q <= ar_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        if (ar_in_range) addr_q <= s_axil_araddr[LMEM_ADDR_WIDTH+1:2];
        else             rdata_q <= '0;
      end
      if (state_q == RD_CAP) rdata_q <= lmem_data_out;
    end
  end

  assign s_axil_awready = grant_wr;
  assign s_axil_wready  = grant_wr;
  assign s_axil_arready = grant_rd;
  assign s_axil_bvalid  = (state_q == WR_RESP);
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = (state_q == RD_RESP);
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;

  // A write with all strobes clear still pulses the port; be=0 makes it a no-op.
  assign lmem_en      = (state_q == WR_MEM) || (state_q == RD_MEM);
  assign lmem_be      = (state_q == WR_MEM) ? be_q : '0;
  assign lmem_addr    = addr_q;
  assign lmem_data_in = wdata_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_prism_sp_lmem_axil_bridge.sv
// Bench for prism_sp_lmem_axil_bridge: vector table plus hand-written sequences for
// arbitration, response backpressure and reset in the middle of a read.
module tb_prism_sp_lmem_axil_bridge;
  import prism_sp_axil_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] s_axil_awaddr = '0, s_axil_wdata = '0, s_axil_araddr = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_awvalid = 1'b0, s_axil_wvalid = 1'b0, s_axil_bready = 1'b0;
  logic        s_axil_arvalid = 1'b0, s_axil_rready = 1'b0;
  logic        s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic [31:0] s_axil_rdata;
  logic [11:0] lmem_addr;
  logic        lmem_en;
  logic [3:0]  lmem_be;
  logic [31:0] lmem_data_in;
  logic [31:0] lmem_data_out = '0;
  lmem_bridge_state_t state_dbg;

  prism_sp_lmem_axil_bridge dut (
    .clock(clock), .resetn(resetn),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .lmem_addr(lmem_addr), .lmem_en(lmem_en), .lmem_be(lmem_be),
    .lmem_data_in(lmem_data_in), .lmem_data_out(lmem_data_out), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  task automatic do_reset();
    resetn = 1'b0;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    s_axil_bready = 1'b0;  s_axil_rready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  // ---------------- BRAM model (1-cycle read latency) ----------------
  logic [31:0] bram [0:4095];
  initial for (int k = 0; k < 4096; k++) bram[k] = '0;

  always @(posedge clock) begin
    if (lmem_en) begin
      if (lmem_be == 4'h0) lmem_data_out <= bram[lmem_addr];
      for (int b = 0; b < 4; b++)
        if (lmem_be[b]) bram[lmem_addr][8*b +: 8] <= lmem_data_in[8*b +: 8];
    end
  end

  // ---------------- port monitor ----------------
  int          en_cnt = 0, en_run = 0, en_run_max = 0;
  logic [11:0] en_addr = '0;
  logic [3:0]  en_be = '0;
  logic [31:0] en_data = '0;

  always @(negedge clock) begin
    if (lmem_en) begin
      en_cnt++; en_run++;
      en_addr = lmem_addr; en_be = lmem_be; en_data = lmem_data_in;
    end else begin
      en_run = 0;
    end
    if (en_run > en_run_max) en_run_max = en_run;
  end

  // ---------------- scoreboard ----------------
  int          n_vec = 0, n_miss = 0;
  logic [33:0] exp_q[$];   // reads: {rresp, rdata}
  logic [1:0]  expb_q[$];  // writes: bresp

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output bit hs, output logic [1:0] resp, output int lat);
    int g;
    @(posedge clock); #1;
    s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    g = 0;
    @(negedge clock);
    while (!(s_axil_awready && s_axil_wready) && g < 20) begin @(negedge clock); g++; end
    hs = s_axil_awready && s_axil_wready;
    @(posedge clock); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!s_axil_bvalid && lat < 20);
    resp = s_axil_bresp;
    s_axil_bready = 1'b1;
    @(posedge clock); #1 s_axil_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output bit hs, output logic [1:0] resp,
                          output logic [31:0] data, output int lat);
    int g;
    @(posedge clock); #1;
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    g = 0;
    @(negedge clock);
    while (!s_axil_arready && g < 20) begin @(negedge clock); g++; end
    hs = s_axil_arready;
    @(posedge clock); #1 s_axil_arvalid = 1'b0;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!s_axil_rvalid && lat < 20);
    resp = s_axil_rresp; data = s_axil_rdata;
    s_axil_rready = 1'b1;
    @(posedge clock); #1 s_axil_rready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic [11:0] exp_word;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    bit          hs;
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat, en0, exp_lat, exp_en, stall_bad, g, wi, ri, gi, nb, nr;
    logic [33:0] e;
    logic [1:0]  eb;
    bit          hs_w, hs_r;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, AXI_RESP_OKAY,   32'h0,         12'h004};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, AXI_RESP_OKAY,   32'hDEAD_BEEF, 12'h004};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, AXI_RESP_OKAY,   32'h0,         12'h008};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, AXI_RESP_OKAY,   32'h0,         12'h008};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, AXI_RESP_OKAY,   32'h11BB_33DD, 12'h008};
    vecs[5]  = '{1'b1, 32'h0000_0010, 32'h0000_0000, 4'h0, AXI_RESP_OKAY,   32'h0,         12'h004};
    vecs[6]  = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, AXI_RESP_OKAY,   32'hDEAD_BEEF, 12'h004};
    vecs[7]  = '{1'b1, 32'h0000_4000, 32'h1234_5678, 4'hF, AXI_RESP_SLVERR, 32'h0,         12'h000};
    vecs[8]  = '{1'b0, 32'h0000_4000, 32'h0,         4'h0, AXI_RESP_SLVERR, 32'h0,         12'h000};
    vecs[9]  = '{1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 4'hF, AXI_RESP_OKAY,   32'h0,         12'hFFF};
    vecs[10] = '{1'b0, 32'h0000_3FFC, 32'h0,         4'h0, AXI_RESP_OKAY,   32'hCAFE_F00D, 12'hFFF};
    vecs[11] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, AXI_RESP_SLVERR, 32'h0,         12'h000};
    vecs[12] = '{1'b1, 32'h0000_4010, 32'h5555_5555, 4'hF, AXI_RESP_SLVERR, 32'h0,         12'h000};
    vecs[13] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, AXI_RESP_OKAY,   32'hDEAD_BEEF, 12'h004};

    // ---- reset state ----
    do_reset();
    #1;
    check("rst_handshake", 64'({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid}), 64'h0);
    check("rst_lmem", 64'({lmem_en, lmem_be, lmem_addr, lmem_data_in}), 64'h0);
    check("rst_resp", 64'({s_axil_rdata, s_axil_bresp, s_axil_rresp}), 64'h0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));

    // ---- table-driven single transactions ----
    for (int i = 0; i < NV; i++) begin
      exp_lat = (vecs[i].exp_resp == AXI_RESP_SLVERR) ? 1 : (vecs[i].is_wr ? 2 : 3);
      exp_en  = (vecs[i].exp_resp == AXI_RESP_SLVERR) ? 0 : 1;
      en0 = en_cnt;
      if (vecs[i].is_wr) begin
        expb_q.push_back(vecs[i].exp_resp);
        axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, hs, resp, lat);
        eb = expb_q.pop_front();
        check($sformatf("v%0d_bresp", i), 64'(resp), 64'(eb));
      end else begin
        exp_q.push_back({vecs[i].exp_resp, vecs[i].exp_rdata});
        axi_read(vecs[i].addr, hs, resp, data, lat);
        e = exp_q.pop_front();
        check($sformatf("v%0d_rresp", i), 64'(resp), 64'(e[33:32]));
        check($sformatf("v%0d_rdata", i), 64'(data), 64'(e[31:0]));
      end
      check($sformatf("v%0d_handshake", i), 64'(hs), 64'h1);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat));
      check($sformatf("v%0d_en_count", i), 64'(en_cnt - en0), 64'(exp_en));
      if (exp_en == 1) begin
        check($sformatf("v%0d_en_addr_be", i), 64'({en_addr, en_be}),
              64'({vecs[i].exp_word, vecs[i].is_wr ? vecs[i].strb : 4'h0}));
        if (vecs[i].is_wr) check($sformatf("v%0d_en_data", i), 64'(en_data), 64'(vecs[i].wdata));
      end
    end

    // ---- contested arbitration: W,R,W,R,... starting with write after reset ----
    do_reset();
    @(posedge clock); #1;
    wi = 0; ri = 0; gi = 0; nb = 0; nr = 0;
    s_axil_awaddr = 32'h100; s_axil_wdata = 32'hA500_0000; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    s_axil_araddr = 32'h100; s_axil_arvalid = 1'b1;
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    expb_q.push_back(AXI_RESP_OKAY);
    exp_q.push_back({AXI_RESP_OKAY, 32'hA500_0000});
    for (int cyc = 0; cyc < 300 && (nb < 4 || nr < 4); cyc++) begin
      @(negedge clock);
      hs_w = s_axil_awvalid && s_axil_awready && s_axil_wvalid && s_axil_wready;
      hs_r = s_axil_arvalid && s_axil_arready;
      if (hs_w || hs_r) begin
        check($sformatf("arb_grant%0d", gi), 64'({hs_w, hs_r}), (gi % 2 == 0) ? 64'h2 : 64'h1);
        gi++;
      end
      if (s_axil_bvalid) begin
        eb = expb_q.pop_front();
        check($sformatf("arb_bresp%0d", nb), 64'(s_axil_bresp), 64'(eb));
        nb++;
      end
      if (s_axil_rvalid) begin
        e = exp_q.pop_front();
        check($sformatf("arb_rdata%0d", nr), 64'({s_axil_rresp, s_axil_rdata}), 64'(e));
        nr++;
      end
      @(posedge clock); #1;
      if (hs_w) begin
        wi++;
        if (wi < 4) begin
          s_axil_awaddr = 32'h100 + 32'(4 * wi); s_axil_wdata = 32'hA500_0000 + 32'(wi);
          expb_q.push_back(AXI_RESP_OKAY);
        end else begin
          s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        end
      end
      if (hs_r) begin
        ri++;
        if (ri < 4) begin
          s_axil_araddr = 32'h100 + 32'(4 * ri);
          exp_q.push_back({AXI_RESP_OKAY, 32'hA500_0000 + 32'(ri)});
        end else begin
          s_axil_arvalid = 1'b0;
        end
      end
    end
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    check("arb_grants", 64'(gi), 64'd8);
    check("arb_responses", 64'({nb[7:0], nr[7:0]}), 64'h0404);

    // ---- backpressure on R with a second AR pending ----
    @(posedge clock); #1;
    s_axil_araddr = 32'h100; s_axil_arvalid = 1'b1;
    g = 0;
    @(negedge clock);
    while (!s_axil_arready && g < 20) begin @(negedge clock); g++; end
    check("bp_ar_handshake", 64'(s_axil_arready), 64'h1);
    @(posedge clock); #1 s_axil_araddr = 32'h104;
    g = 0;
    @(negedge clock);
    while (!s_axil_rvalid && g < 20) begin @(negedge clock); g++; end
    check("bp_rdata", 64'({s_axil_rresp, s_axil_rdata}), 64'({AXI_RESP_OKAY, 32'hA500_0000}));
    stall_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (!s_axil_rvalid || s_axil_rdata !== 32'hA500_0000 || s_axil_arready) stall_bad++;
    end
    check("bp_stall_stable", 64'(stall_bad), 64'h0);
    s_axil_rready = 1'b1;
    @(posedge clock); #1 s_axil_rready = 1'b0;
    @(negedge clock);
    check("bp_ar_after_r", 64'(s_axil_arready), 64'h1);
    @(posedge clock); #1 s_axil_arvalid = 1'b0;
    g = 0;
    @(negedge clock);
    while (!s_axil_rvalid && g < 20) begin @(negedge clock); g++; end
    check("bp_second_rdata", 64'({s_axil_rresp, s_axil_rdata}), 64'({AXI_RESP_OKAY, 32'hA500_0001}));
    s_axil_rready = 1'b1;
    @(posedge clock); #1 s_axil_rready = 1'b0;

    // ---- reset while in RD_MEM ----
    @(posedge clock); #1;
    s_axil_araddr = 32'h3FFC; s_axil_arvalid = 1'b1;
    g = 0;
    @(negedge clock);
    while (!s_axil_arready && g < 20) begin @(negedge clock); g++; end
    @(posedge clock); #1 s_axil_arvalid = 1'b0;
    check("rst_mid_pre_state", 64'({state_dbg, lmem_en}), 64'({RD_MEM, 1'b1}));
    #1 resetn = 1'b0;
    #1;
    check("rst_mid_state", 64'(state_dbg), 64'(IDLE));
    check("rst_mid_lmem", 64'({lmem_en, lmem_be, lmem_addr, lmem_data_in}), 64'h0);
    check("rst_mid_axi", 64'({s_axil_awready, s_axil_arready, s_axil_bvalid, s_axil_rvalid,
                              s_axil_bresp, s_axil_rresp, s_axil_rdata}), 64'h0);
    @(negedge clock);
    resetn = 1'b1;
    axi_read(32'h3FFC, hs, resp, data, lat);
    check("rst_mid_next_read", 64'({hs, resp, data}), 64'({1'b1, AXI_RESP_OKAY, 32'hCAFE_F00D}));
    check("rst_mid_next_lat", 64'(lat), 64'd3);

    check("en_pulse_width", 64'(en_run_max), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/prism_sp_lmem_axil_bridge.md
Name: prism_sp_lmem_axil_bridge

Overview:
AXI4-Lite slave that drives the MMR port of a local memory from the host side. It is the initiator end of the `local_memory_interface` MMR port on the SP instruction and data BRAMs. The PS uses it to load SP firmware into the instruction BRAM and to inspect or patch the data BRAM while the SP core is held in `cpu_reset`. One instance serves one BRAM; the memory port has a read latency of 1 cycle.

Parameters:
AXI_ADDR_WIDTH, 32, width of the AXI byte address.
LMEM_ADDR_WIDTH, 12, width of the local-memory word address; window size is 4*2^LMEM_ADDR_WIDTH bytes.
DATA_WIDTH, 32, AXI and memory data width; only 32 is legal (elaboration error otherwise).

Ports:
clock  in  1  single clock; also drives the BRAM.
resetn  in  1  asynchronous, active-low reset.
s_axil_awaddr  in  AXI_ADDR_WIDTH  write address.
s_axil_awvalid / s_axil_awready  in/out  1  AW handshake.
s_axil_wdata  in  32  write data.
s_axil_wstrb  in  4  byte strobes.
s_axil_wvalid / s_axil_wready  in/out  1  W handshake.
s_axil_bresp  out  2  write response.
s_axil_bvalid / s_axil_bready  out/in  1  B handshake.
s_axil_araddr  in  AXI_ADDR_WIDTH  read address.
s_axil_arvalid / s_axil_arready  in/out  1  AR handshake.
s_axil_rdata  out  32  read data.
s_axil_rresp  out  2  read response.
s_axil_rvalid / s_axil_rready  out/in  1  R handshake.
lmem_addr  out  LMEM_ADDR_WIDTH  word address to the BRAM port.
lmem_en  out  1  BRAM port enable.
lmem_be  out  4  byte write enables; all-zero means a read.
lmem_data_in  out  32  write data to the BRAM.
lmem_data_out  in  32  BRAM read data, valid 1 cycle after an enabled read.

Behaviour:
- Reset: state=IDLE. All ready and valid outputs are 0. lmem_en=0, lmem_be=0, lmem_addr=0, lmem_data_in=0, s_axil_rdata=0, both resp outputs=0, last_grant=READ.
- Only one transaction is outstanding at a time.
- FSM states: IDLE, WR_MEM, WR_RESP, RD_MEM, RD_CAP, RD_RESP.
- IDLE, write candidate: awvalid and wvalid are both high. AW and W are accepted only together.
- IDLE, read candidate: arvalid is high.
- IDLE arbitration when both candidates are present: grant the opposite of last_grant (round-robin).
- Ready signals: awready=wready=1 combinationally only in IDLE with a write grant. arready=1 only in IDLE with a read grant. Ready depends on valid; valid never depends on ready.
- Address decode: word = axaddr[LMEM_ADDR_WIDTH+1:2]. axaddr[1:0] is ignored. in_range = (axaddr[AXI_ADDR_WIDTH-1:LMEM_ADDR_WIDTH+2]==0).
- Write, in range: WR_MEM lasts one cycle with lmem_en=1, lmem_be=wstrb, registered addr/data. Then WR_RESP with bresp=OKAY.
- Write, wstrb=0: the memory write is still issued with be=0 and is harmless. It is not treated as a read.
- Write, out of range: skip WR_MEM, go straight to WR_RESP with bresp=SLVERR. No memory access.
- WR_RESP: bvalid=1 and held until bready, then return to IDLE. The earliest accept in IDLE is the cycle after the B handshake.
- Read, in range: RD_MEM with lmem_en=1, be=0. RD_CAP registers lmem_data_out into rdata. RD_RESP with rresp=OKAY.
- Read, out of range: rdata=0, rresp=SLVERR, go directly to RD_RESP. No memory access.
- RD_RESP: rvalid=1, and rdata/rresp stay stable until rready.
- Latency from handshake to response valid: in-range write 2 cycles, in-range read 3 cycles, error 1 cycle.
- lmem_en is high for exactly one cycle per in-range access and is 0 in all other states.
- Backpressure: bready/rready held low for N cycles stalls the FSM indefinitely. No new AW/W/AR is accepted meanwhile.
- Reset asserted mid-transaction: immediate return to reset values; the pending response is dropped. A partially issued write may have landed in the BRAM.

Decomposition:
- Package prism_sp_axil_pkg:
  - AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10.
  - lmem_bridge_state_t enum.
  - grant_t {GRANT_READ, GRANT_WRITE}.
- No sub-module. A single FSM module is natural; instances are placed per BRAM at the SoC top.

Test Plan:
- Write 0xDEADBEEF to 0x10 with wstrb=0xF, then read 0x10 -> bresp=OKAY, lmem_addr=4 with be=0xF for 1 cycle, rdata=0xDEADBEEF, rresp=OKAY, rvalid exactly 3 cycles after the AR handshake.
- Preload 0x11223344 at 0x20, write 0xAABBCCDD with wstrb=0x5, read back -> 0x11BB33DD.
- Write and read with address 4*2^LMEM_ADDR_WIDTH (first out-of-range word) -> SLVERR on both, lmem_en never asserted, rdata=0.
- AW+W and AR valid in the same cycle, repeated 4 times -> grants alternate W,R,W,R starting with write after reset; data is consistent.
- Hold rready low 10 cycles with a new AR pending -> rvalid and rdata stable, arready stays 0 until 1 cycle after the R handshake.
- Deassert resetn while in RD_MEM -> all outputs at reset values in the same cycle; the next read completes normally.
